// File: rtl/timer_seq_ctrl.sv
// Sequencing controller for the stopwatch/countdown datapath.
// Owns the count register, the countdown preset and the alarm LED.
module timer_seq_ctrl #(
   parameter int UP_MAX_C  = 59,
   parameter int UP_MAX_F  = 999,
   parameter int INIT_DEF  = 30,
   parameter int SET_MIN_C = 10,
   parameter int SET_MAX_C = 99,
   parameter int SET_MIN_F = 100,
   parameter int SET_MAX_F = 999,
   parameter int WARN_C    = 5,
   parameter int WARN_F    = 50,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk_50M,
   input  logic       reset_btn,
   input  logic       tick,
   input  logic       precision,
   input  logic       start_pulse,
   input  logic       clear_pulse,
   input  logic       mode_pulse,
   input  logic       set_pulse,
   input  logic       inc_pulse,
   input  logic       dec_pulse,
   output logic [9:0] value,
   output logic [9:0] preset,
   output logic       mode_down,
   output logic       running,
   output logic       setting,
   output logic       done,
   output logic       led
);

   localparam int CW = $clog2(BLINK_DIV + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [9:0]    value_n, preset_n;
   logic          mode_n, prec_q, prec_n;
   logic [9:0]    up_max, set_min, set_max, warn;
   logic [9:0]    reload_v, new_min;
   logic          blink_on;
   logic [CW-1:0] blink_cnt;

   // Limits for the precision currently latched, plus the reload value.
   always_comb begin
      up_max   = prec_q ? 10'(UP_MAX_F)  : 10'(UP_MAX_C);
      set_min  = prec_q ? 10'(SET_MIN_F) : 10'(SET_MIN_C);
      set_max  = prec_q ? 10'(SET_MAX_F) : 10'(SET_MAX_C);
      warn     = prec_q ? 10'(WARN_F)    : 10'(WARN_C);
      new_min  = precision ? 10'(SET_MIN_F) : 10'(SET_MIN_C);
      reload_v = mode_down ? preset : 10'd0;
   end

   // Next state and next register values; clear > start > set > mode > inc/dec > tick.
   // A precision change while editable takes the whole cycle, dropping key pulses.
   always_comb begin
      state_n  = state;
      value_n  = value;
      preset_n = preset;
      mode_n   = mode_down;
      prec_n   = prec_q;
      if ((state == S_IDLE || state == S_SET) && precision != prec_q) begin
         prec_n   = precision;
         preset_n = new_min;
         value_n  = mode_down ? new_min : 10'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (clear_pulse) begin
                  value_n = reload_v;
               end else if (start_pulse) begin
                  state_n = S_RUN;
               end else if (set_pulse && mode_down) begin
                  state_n = S_SET;
               end else if (mode_pulse) begin
                  mode_n  = ~mode_down;
                  value_n = mode_down ? 10'd0 : preset;
               end
            end
            S_SET: begin
               if (clear_pulse) begin
                  state_n = S_IDLE;
                  value_n = reload_v;
               end else if (start_pulse) begin
                  state_n = S_RUN;
                  value_n = preset;
               end else if (set_pulse) begin
                  state_n = S_IDLE;
               end else if (inc_pulse) begin
                  preset_n = (preset >= set_max) ? set_max : preset + 10'd1;
                  value_n  = preset_n;
               end else if (dec_pulse) begin
                  preset_n = (preset <= set_min) ? set_min : preset - 10'd1;
                  value_n  = preset_n;
               end
            end
            S_RUN: begin
               if (clear_pulse) begin
                  state_n = S_IDLE;
                  value_n = reload_v;
               end else if (start_pulse) begin
                  state_n = S_PAUSE;
               end else if (tick) begin
                  if (!mode_down) begin
                     value_n = (value == up_max) ? 10'd0 : value + 10'd1;
                  end else begin
                     value_n = value - 10'd1;
                     if (value == 10'd1) state_n = S_DONE;
                  end
               end
            end
            S_PAUSE: begin
               if (clear_pulse) begin
                  state_n = S_IDLE;
                  value_n = reload_v;
               end else if (start_pulse) begin
                  state_n = S_RUN;
               end
            end
            S_DONE: begin
               value_n = 10'd0;
               if (start_pulse || clear_pulse) begin
                  state_n = S_IDLE;
                  value_n = reload_v;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_50M or posedge reset_btn) begin
      if (reset_btn) begin
         state     <= S_IDLE;
         value     <= 10'd0;
         preset    <= 10'(INIT_DEF);
         mode_down <= 1'b0;
         prec_q    <= precision;
      end else begin
         state     <= state_n;
         value     <= value_n;
         preset    <= preset_n;
         mode_down <= mode_n;
         prec_q    <= prec_n;
      end
   end

   assign running  = (state == S_RUN);
   assign setting  = (state == S_SET);
   assign done     = (state == S_DONE);
   assign blink_on = (state == S_DONE) ||
                     (state == S_RUN && mode_down && value <= warn);

   // Alarm blink: restart the divider whenever the blink condition drops.
   always_ff @(posedge clk_50M or posedge reset_btn) begin
      if (reset_btn) begin
         blink_cnt <= '0;
         led       <= 1'b0;
      end else if (!blink_on) begin
         blink_cnt <= '0;
         led       <= 1'b0;
      end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         led       <= ~led;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

endmodule
